// File: rtl/dmem_2p_responder_if.sv
// dmem_2p_responder_if
//   Two-port data-memory bus between the MA stage (master) and the data RAM
//   responder (slave). The write port and the read port are independent. Each
//   port can carry one word per cycle.
//   master : drives waddr/wdata/wen/raddr/ren, samples rdata/rvalid/ready
//   slave  : the reverse direction
interface dmem_2p_responder_if #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int MEM_DATA_WIDTH = 32
) ();
  logic [MEM_ADDR_WIDTH-1:0] dmem_waddr;
  logic [MEM_DATA_WIDTH-1:0] dmem_wdata;
  logic                      dmem_wen;
  logic [MEM_ADDR_WIDTH-1:0] dmem_raddr;
  logic                      dmem_ren;
  logic [MEM_DATA_WIDTH-1:0] dmem_rdata;
  logic                      dmem_rvalid;
  logic                      dmem_ready;

  modport master (
    output dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren,
    input  dmem_rdata, dmem_rvalid, dmem_ready
  );

  modport slave (
    input  dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren,
    output dmem_rdata, dmem_rvalid, dmem_ready
  );
endinterface

// File: rtl/dmem_2p_responder.sv
// dmem_2p_responder
//   Data RAM responder for the CPU's true two-port data-memory interface.
//   After every reset, the block zero-fills the array one word per cycle (INIT).
//   It then serves one write and one read per cycle (READY). Read data is
//   registered and arrives one cycle after the request.
//
//   Ports:
//     clk  - single clock. All state changes on its rising edge.
//     rst  - asynchronous reset, active low.
//     bus  - dmem_2p_responder_if.slave. It carries the write port
//            (waddr/wdata/wen), the read port (raddr/ren -> rdata/rvalid)
//            and the init-done flag (ready).
//
//   Configuration macro: DMEM_RDW_BYPASS_EN
//     defined   - a same-address read and write on one edge returns the new
//                 write data (write-first).
//     undefined - the same case returns the old array contents (read-first).
module dmem_2p_responder #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int MEM_DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_2p_responder_if.slave   bus
);

  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                    state_q,    state_d;
  logic [MEM_ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [MEM_DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic                      rvalid_q,   rvalid_d;
  logic                      ready_q,    ready_d;

  // The array has no reset. The INIT walk is what clears it.
  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

  // A single write port is shared between the init clear and the bus writes.
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_wa;
  logic [MEM_DATA_WIDTH-1:0] mem_wd;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rdata_d    = rdata_q;     // rdata holds between reads
    rvalid_d   = 1'b0;        // rvalid is a one-cycle pulse per accepted read
    ready_d    = ready_q;
    mem_we     = 1'b0;
    mem_wa     = '0;
    mem_wd     = '0;

    case (state_q)
      S_INIT: begin
        // Bus requests are ignored while the array is being cleared.
        mem_we     = 1'b1;
        mem_wa     = init_cnt_q;
        mem_wd     = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end

      S_READY: begin
        mem_we = bus.dmem_wen;
        mem_wa = bus.dmem_waddr;
        mem_wd = bus.dmem_wdata;
        if (bus.dmem_ren) begin
          rvalid_d = 1'b1;
          // The array read sees the contents from before this edge's write,
          // so the default build is read-first without any extra logic.
          rdata_d  = mem[bus.dmem_raddr];
`ifdef DMEM_RDW_BYPASS_EN
          if (bus.dmem_wen && (bus.dmem_waddr == bus.dmem_raddr))
            rdata_d = bus.dmem_wdata;
`endif
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      ready_q    <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  assign bus.dmem_rdata  = rdata_q;
  assign bus.dmem_rvalid = rvalid_q;
  assign bus.dmem_ready  = ready_q;

endmodule

// File: doc/dmem_2p_responder.md
# dmem_2p_responder

Responder side of the CPU's true two-port data-memory interface: it consumes the write and read requests driven by the MA stage and returns read data one cycle later. After every reset it sequentially zero-fills its array and only then accepts traffic. It sits beside the CPU top and serves as both the synthesizable data RAM wrapper and the bench's memory model.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 12, word address width; depth = 2**MEM_ADDR_WIDTH words.
- MEM_DATA_WIDTH, 32, word width in bits.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- dmem_waddr  in  MEM_ADDR_WIDTH  write word address.
- dmem_wdata  in  MEM_DATA_WIDTH  write data.
- dmem_wen  in  1  write request, one word per cycle.
- dmem_raddr  in  MEM_ADDR_WIDTH  read word address.
- dmem_ren  in  1  read request, one word per cycle.
- dmem_rdata  out  MEM_DATA_WIDTH  registered read data.
- dmem_rvalid  out  1  high for exactly the cycle in which dmem_rdata carries the response to a read accepted on the previous edge.
- dmem_ready  out  1  high once initialization completes; requests are accepted only while it is high.

## Operation
- FSM states:
  - INIT:
    - Entered on reset.
    - An init counter walks 0..DEPTH-1 and writes 0 to one word per cycle.
    - On the edge that writes DEPTH-1, go to READY.
  - READY: normal service. There is no exit other than reset.
- In INIT:
  - dmem_wen and dmem_ren are ignored. No array write occurs and no rvalid is produced.
  - dmem_ready is 0.
- In READY:
  - Write: on an edge with dmem_wen=1, mem[dmem_waddr] <= dmem_wdata.
  - Read: on an edge with dmem_ren=1, dmem_rdata <= mem[dmem_raddr] and dmem_rvalid <= 1.
  - When dmem_ren=0: dmem_rdata holds its last value and dmem_rvalid <= 0.
- Both ports may be active on the same edge, to different or equal addresses; see Configuration for the equal-address case.
- There are no backpressure or stall outputs. Every request accepted in READY completes.
- Addresses are word addresses and wrap naturally at MEM_ADDR_WIDTH bits. There is no out-of-range condition.
- Reset mid-operation (any state):
  - The FSM immediately returns to INIT and the init counter goes to 0.
  - The array is re-zeroed in full.
  - Any in-flight read response is dropped (rvalid forced to 0).

## Timing
- Reset values: dmem_rdata=0, dmem_rvalid=0, dmem_ready=0, FSM=INIT, init counter=0.
- Init duration: DEPTH cycles after reset deassertion. dmem_ready rises on the edge after the last clear, i.e. after 4096 edges at default parameters.
- Read latency is 1 cycle: ren sampled at edge N, rdata/rvalid valid after edge N until edge N+1.
- Write latency is 1 cycle: a write at edge N is visible to a read request sampled at edge N+1 or later.
- Throughput: one read and one write per cycle, sustained.
- A request presented in the same cycle dmem_ready first reads 1 is accepted. A request presented while dmem_ready=0 is lost; the initiator must wait for ready.

## Configuration
- Macro: DMEM_RDW_BYPASS_EN.
- Defined: for a read and a write to the same address on the same edge, dmem_rdata returns the new dmem_wdata (write-first).
- Undefined: the same case returns the array contents from before the write (read-first). The array is still updated.
- Neither mode affects different-address accesses.

## Test plan
- Reset release -> dmem_ready=0 for exactly 4096 cycles, then 1; a read of addr 0x000 and of addr 0xFFF both return 0 with rvalid one cycle after ren.
- In READY, write 0xDEADBEEF to 0x123, then ren to 0x123 the next cycle -> rdata=0xDEADBEEF, rvalid pulse of 1 cycle; with ren low afterwards, rdata holds 0xDEADBEEF and rvalid=0.
- Same-edge write 0x11111111 and read at 0x040, where old value is 0x22222222 -> rdata=0x11111111 with DMEM_RDW_BYPASS_EN, 0x22222222 without; a later read returns 0x11111111 in both modes.
- wen/ren asserted during INIT (write 0xA5A5A5A5 to 0x010) -> no rvalid; after ready, a read of 0x010 returns 0.
- Back-to-back reads of 0x001, 0x002, 0x003 with concurrent writes to 0x100..0x102 -> three consecutive rvalid cycles carrying correct data; the writes all land.
- Pull rst low during READY with ren active -> rvalid and ready drop immediately; after release, ready returns after 4096 cycles and all previously written locations read 0.
